// File: rtl/cloud_neighbor_diff.sv
// rtl/cloud_neighbor_diff.sv - raster neighbour differences (cur-left, cur-up) for normal estimation
package RgbdVoConfigPk;
   parameter int CLOUD_BW = 16;
endpackage

module cloud_neighbor_diff
   import RgbdVoConfigPk::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_frame_start,
   input  logic                       i_valid,
   input  logic signed [CLOUD_BW-1:0] i_x,
   input  logic signed [CLOUD_BW-1:0] i_y,
   input  logic signed [CLOUD_BW-1:0] i_z,
   output logic                       o_valid,
   output logic signed [CLOUD_BW-1:0] o_p0_x,
   output logic signed [CLOUD_BW-1:0] o_p0_y,
   output logic signed [CLOUD_BW-1:0] o_p0_z,
   output logic signed [CLOUD_BW-1:0] o_p1_x,
   output logic signed [CLOUD_BW-1:0] o_p1_y,
   output logic signed [CLOUD_BW-1:0] o_p1_z,
   output logic                       o_nb_ok,
   output logic                       o_frame_done,
   output logic                       o_frame_err
);
   localparam int BW = CLOUD_BW;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_col, w_col_nxt, w_pos_col;
   logic [RW-1:0]   r_row, w_row_nxt, w_pos_row;
   logic            w_acc, w_err_set, w_emit, w_last, w_cur_ok;

   logic [3*BW:0]   r_mem [IMG_W];
   logic [3*BW:0]   r_rd;
   logic signed [BW-1:0] w_up_x, w_up_y, w_up_z;

   logic signed [BW-1:0] r_lft_x, r_lft_y, r_lft_z;
   logic                 r_lft_ok;
   logic signed [BW-1:0] r_s1_x, r_s1_y, r_s1_z, r_s1_lx, r_s1_ly, r_s1_lz;
   logic                 r_s1_vld, r_s1_last, r_s1_ok, r_s1_lok;
   logic signed [BW:0]   r_s2_d0x, r_s2_d0y, r_s2_d0z, r_s2_d1x, r_s2_d1y, r_s2_d1z;
   logic                 r_s2_vld, r_s2_last, r_s2_ok;

   function automatic logic signed [BW:0] f_sub(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b);
      return {a[BW-1], a} - {b[BW-1], b};
   endfunction

   function automatic logic signed [BW-1:0] f_sat(input logic signed [BW:0] d);
      if (d[BW] != d[BW-1])
         return d[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      return d[BW-1:0];
   endfunction

   // A frame start is always honoured as pixel (0,0); it is an error only mid-frame.
   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_pos_col   = r_col;
      w_pos_row   = r_row;
      w_acc       = 1'b0;
      w_err_set   = 1'b0;
      if (i_valid) begin
         if (i_frame_start) begin
            w_acc       = 1'b1;
            w_pos_col   = '0;
            w_pos_row   = '0;
            w_err_set   = (r_state != IDLE) && ((r_col != '0) || (r_row != '0));
            w_col_nxt   = CW'(1);
            w_row_nxt   = '0;
            w_state_nxt = FILL;
         end else if (r_state == IDLE) begin
            w_err_set = 1'b1;
         end else begin
            w_acc = 1'b1;
            if (r_col == CW'(IMG_W-1)) begin
               w_col_nxt = '0;
               if (r_row == RW'(IMG_H-1)) begin
                  w_row_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_row_nxt   = r_row + RW'(1);
                  w_state_nxt = RUN;
               end
            end else begin
               w_col_nxt = r_col + CW'(1);
            end
         end
      end
      w_emit = w_acc && (w_pos_row != '0) && (w_pos_col != '0);
      w_last = w_acc && (w_pos_row == RW'(IMG_H-1)) && (w_pos_col == CW'(IMG_W-1));
   end

   assign w_cur_ok = (i_z != '0);
   assign w_up_x   = r_rd[BW-1:0];
   assign w_up_y   = r_rd[2*BW-1:BW];
   assign w_up_z   = r_rd[3*BW-1:2*BW];

   // Read-before-write: r_rd holds the row-above entry for the pixel just written.
   always_ff @(posedge i_clk) begin
      if (w_acc) begin
         r_rd                <= r_mem[w_pos_col];
         r_mem[w_pos_col]    <= {w_cur_ok, i_z, i_y, i_x};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_col    <= '0;
         r_row    <= '0;
         r_lft_x  <= '0; r_lft_y <= '0; r_lft_z <= '0; r_lft_ok <= 1'b0;
         r_s1_x   <= '0; r_s1_y  <= '0; r_s1_z  <= '0;
         r_s1_lx  <= '0; r_s1_ly <= '0; r_s1_lz <= '0;
         r_s1_vld <= 1'b0; r_s1_last <= 1'b0; r_s1_ok <= 1'b0; r_s1_lok <= 1'b0;
         r_s2_d0x <= '0; r_s2_d0y <= '0; r_s2_d0z <= '0;
         r_s2_d1x <= '0; r_s2_d1y <= '0; r_s2_d1z <= '0;
         r_s2_vld <= 1'b0; r_s2_last <= 1'b0; r_s2_ok <= 1'b0;
         o_valid  <= 1'b0;
         o_p0_x   <= '0; o_p0_y <= '0; o_p0_z <= '0;
         o_p1_x   <= '0; o_p1_y <= '0; o_p1_z <= '0;
         o_nb_ok  <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_col       <= w_col_nxt;
         r_row       <= w_row_nxt;
         o_frame_err <= o_frame_err | w_err_set;

         r_s1_vld  <= w_emit;
         r_s1_last <= w_last;
         if (w_acc) begin
            r_s1_x   <= i_x;     r_s1_y  <= i_y;     r_s1_z  <= i_z;   r_s1_ok  <= w_cur_ok;
            r_s1_lx  <= r_lft_x; r_s1_ly <= r_lft_y; r_s1_lz <= r_lft_z; r_s1_lok <= r_lft_ok;
            r_lft_x  <= i_x;     r_lft_y <= i_y;     r_lft_z <= i_z;   r_lft_ok <= w_cur_ok;
         end

         r_s2_vld  <= r_s1_vld;
         r_s2_last <= r_s1_last;
         if (r_s1_vld) begin
            r_s2_d0x <= f_sub(r_s1_x, r_s1_lx);
            r_s2_d0y <= f_sub(r_s1_y, r_s1_ly);
            r_s2_d0z <= f_sub(r_s1_z, r_s1_lz);
            r_s2_d1x <= f_sub(r_s1_x, w_up_x);
            r_s2_d1y <= f_sub(r_s1_y, w_up_y);
            r_s2_d1z <= f_sub(r_s1_z, w_up_z);
            r_s2_ok  <= r_s1_ok & r_s1_lok & r_rd[3*BW];
         end

         o_valid      <= r_s2_vld;
         o_frame_done <= r_s2_vld & r_s2_last;
         if (r_s2_vld) begin
            o_p0_x  <= f_sat(r_s2_d0x);
            o_p0_y  <= f_sat(r_s2_d0y);
            o_p0_z  <= f_sat(r_s2_d0z);
            o_p1_x  <= f_sat(r_s2_d1x);
            o_p1_y  <= f_sat(r_s2_d1y);
            o_p1_z  <= f_sat(r_s2_d1z);
            o_nb_ok <= r_s2_ok;
         end
      end
   end
endmodule

// File: tb/tb_cloud_neighbor_diff.sv
// tb/tb_cloud_neighbor_diff.sv - self-checking bench for cloud_neighbor_diff
module tb_cloud_neighbor_diff;
   import RgbdVoConfigPk::*;
   localparam int W    = 3;
   localparam int H    = 2;
   localparam int BW   = CLOUD_BW;
   localparam int MAXV = (1 << (BW-1)) - 1;
   localparam int MINV = -(1 << (BW-1));

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, fs, vld;
   logic signed [BW-1:0] x, y, z;
   logic o_valid, o_nb_ok, o_frame_done, o_frame_err;
   logic signed [BW-1:0] p0x, p0y, p0z, p1x, p1y, p1z;

   cloud_neighbor_diff #(.IMG_W(W), .IMG_H(H)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_valid(vld),
      .i_x(x), .i_y(y), .i_z(z),
      .o_valid(o_valid),
      .o_p0_x(p0x), .o_p0_y(p0y), .o_p0_z(p0z),
      .o_p1_x(p1x), .o_p1_y(p1y), .o_p1_z(p1z),
      .o_nb_ok(o_nb_ok), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
   );

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: whole frame image kept as plain integers.
   typedef struct {
      int due;
      int p0x, p0y, p0z, p1x, p1y, p1z;
      bit ok;
      bit last;
   } exp_t;
   exp_t q[$];
   int   img_x [H][W];
   int   img_y [H][W];
   int   img_z [H][W];
   int   m_r = 0, m_c = 0, cyc = 0;
   bit   m_in = 0, m_err = 0, m_take;

   function automatic int clamp(input int d);
      if (d > MAXV) return MAXV;
      if (d < MINV) return MINV;
      return d;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         q.delete();
         m_in = 0; m_err = 0; m_r = 0; m_c = 0;
      end else if (vld) begin
         m_take = 1;
         if (fs) begin
            if (m_in && (m_r != 0 || m_c != 0)) m_err = 1;
            m_r = 0; m_c = 0; m_in = 1;
         end else if (!m_in) begin
            m_err  = 1;
            m_take = 0;
         end
         if (m_take) begin
            img_x[m_r][m_c] = int'(x);
            img_y[m_r][m_c] = int'(y);
            img_z[m_r][m_c] = int'(z);
            if (m_r > 0 && m_c > 0) begin
               e.due  = cyc + 2;
               e.p0x  = clamp(img_x[m_r][m_c] - img_x[m_r][m_c-1]);
               e.p0y  = clamp(img_y[m_r][m_c] - img_y[m_r][m_c-1]);
               e.p0z  = clamp(img_z[m_r][m_c] - img_z[m_r][m_c-1]);
               e.p1x  = clamp(img_x[m_r][m_c] - img_x[m_r-1][m_c]);
               e.p1y  = clamp(img_y[m_r][m_c] - img_y[m_r-1][m_c]);
               e.p1z  = clamp(img_z[m_r][m_c] - img_z[m_r-1][m_c]);
               e.ok   = (img_z[m_r][m_c] != 0) && (img_z[m_r][m_c-1] != 0) && (img_z[m_r-1][m_c] != 0);
               e.last = (m_r == H-1) && (m_c == W-1);
               q.push_back(e);
            end
            m_c++;
            if (m_c == W) begin
               m_c = 0;
               m_r++;
               if (m_r == H) begin
                  m_r  = 0;
                  m_in = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      bit   expv;
      while (q.size() > 0 && q[0].due < cyc) begin
         chk("missed_output", 0, 1);
         void'(q.pop_front());
      end
      expv = (q.size() > 0) && (q[0].due == cyc);
      chk("valid", int'(o_valid), int'(expv));
      chk("frame_err", int'(o_frame_err), int'(m_err));
      if (expv) begin
         e = q.pop_front();
         if (o_valid) n_out++;
         chk("p0x", int'(p0x), e.p0x);
         chk("p0y", int'(p0y), e.p0y);
         chk("p0z", int'(p0z), e.p0z);
         chk("p1x", int'(p1x), e.p1x);
         chk("p1y", int'(p1y), e.p1y);
         chk("p1z", int'(p1z), e.p1z);
         chk("nb_ok", int'(o_nb_ok), int'(e.ok));
         chk("frame_done", int'(o_frame_done), int'(e.last));
      end else begin
         chk("done_idle", int'(o_frame_done), 0);
      end
   end

   task automatic px(input bit s, input int vx, input int vy, input int vz);
      vld = 1'b1; fs = s;
      x = vx[BW-1:0]; y = vy[BW-1:0]; z = vz[BW-1:0];
      @(posedge clk); #1;
      vld = 1'b0; fs = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, int'(o_valid), 0);
      chk({tag, "_p0x"}, int'(p0x), 0);
      chk({tag, "_p1z"}, int'(p1z), 0);
      chk({tag, "_nb_ok"}, int'(o_nb_ok), 0);
      chk({tag, "_done"}, int'(o_frame_done), 0);
      chk({tag, "_err"}, int'(o_frame_err), 0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   int fx [6] = '{1, 2, 4, 1, 3, 6};
   int fy [6] = '{1, 1, 1, 2, 2, 3};
   int fz [6] = '{10, 12, 15, 11, 14, 20};

   task automatic send_frame(input int gapmax, input bit zero_up);
      for (int i = 0; i < 6; i++) begin
         px(i == 0, fx[i], fy[i], (zero_up && i == 1) ? 0 : fz[i]);
         if (gapmax > 0) gap($urandom_range(0, gapmax));
      end
   endtask

   function automatic int rnd_val();
      logic signed [BW-1:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) return int'(t);
      return int'($urandom_range(0, 200)) - 100;
   endfunction

   initial begin
      int base;
      rst_n = 1'b0; fs = 1'b0; vld = 1'b0; x = '0; y = '0; z = '0;
      gap(2);
      rst_n = 1'b1;
      chk_zero("reset");

      base = n_out;
      send_frame(0, 0);
      gap(4);
      chk("t1_count", n_out - base, 2);

      base = n_out;
      send_frame(0, 1);
      gap(4);
      chk("t2_count", n_out - base, 2);

      px(1, 0, 0, 1);       px(0, MINV, MAXV, 1); px(0, MAXV, MINV, 1);
      px(0, -5, 0, 1);      px(0, MAXV, MINV, 1); px(0, MINV, MAXV, 1);
      gap(4);

      base = n_out;
      send_frame(5, 0);
      gap(6);
      chk("t4_count", n_out - base, 2);

      for (int i = 0; i < 4; i++) px(i == 0, fx[i], fy[i], fz[i]);
      px(1, 7, 7, 7);
      for (int i = 1; i < 6; i++) px(0, fx[i], fy[i], fz[i]);
      gap(3);
      px(0, 9, 9, 9);
      gap(4);

      pulse_reset();
      for (int i = 0; i < 5; i++) px(i == 0, fx[i], fy[i], fz[i]);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_zero("midrun_rst");
      gap(2);
      base = n_out;
      send_frame(0, 0);
      gap(4);
      chk("t6_count", n_out - base, 2);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset();
         else if ($urandom_range(0, 2) == 0) gap(1);
         else px(!m_in ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0),
                 rnd_val(), rnd_val(), ($urandom_range(0, 7) == 0) ? 0 : rnd_val());
      end
      gap(5);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
